// File: rtl/mux_scan_sequencer_if.sv
// Bundle of scan-control, mux-select and result signals between the sequencer
// and whatever drives/observes it (bench or downstream logic).
interface mux_scan_sequencer_if;
  logic       start;
  logic       abort;
  logic       mux_out;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       done;
  logic [3:0] result;

  modport master (
    output start, abort, mux_out,
    input  s0, s1, busy, done, result
  );

  modport slave (
    input  start, abort, mux_out,
    output s0, s1, busy, done, result
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scans a 4-to-1 mux through channels A..D, settles, samples, and publishes a 4-bit word.
// Optional free-running mode: define CONTINUOUS_SCAN_EN to loop DONE back into SETTLE.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [3:0]       result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    result_d = result_q;
    done_d   = 1'b0;

    if (bus.abort) begin
      // Abort outranks any sample or transition, and also masks start in IDLE.
      state_d = IDLE;
      ch_d    = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = SETTLE;
            ch_d    = 2'd0;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) state_d = SAMPLE;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        SAMPLE: begin
          if (ch_q != 2'd3) begin
            shadow_d[ch_q] = bus.mux_out;
            ch_d           = ch_q + 2'd1;
            cnt_d          = '0;
            state_d        = SETTLE;
          end else begin
            // Last channel goes straight into result; earlier ones wait in shadow.
            result_d = {bus.mux_out, shadow_q};
            done_d   = 1'b1;
            ch_d     = 2'd0;
            state_d  = DONE;
          end
        end
        DONE: begin
`ifdef CONTINUOUS_SCAN_EN
          state_d = SETTLE;
          ch_d    = 2'd0;
          cnt_d   = '0;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 3'd0;
      result_q <= 4'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Selects follow the channel register directly; ch is held at 0 in IDLE and DONE.
  assign bus.s0     = ch_q[0];
  assign bus.s1     = ch_q[1];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a behavioural mux plus a per-cycle model of the
// expected select sequence, done timing and result word for randomized channel data.
module tb_mux_scan_sequencer;

  localparam int SETTLE = 2;
  localparam int PER_CH = SETTLE + 1;
  localparam int LAT    = 4 * PER_CH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_sequencer_if bus();

  mux_scan_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural 4-to-1 mux: channel i of chan appears when {s1,s0} == i.
  logic [3:0] chan;
  assign bus.mux_out = chan[{bus.s1, bus.s0}];

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_result;

  // {busy, done, s1, s0, result}
  function automatic logic [7:0] obs();
    return {bus.busy, bus.done, bus.s1, bus.s0, bus.result};
  endfunction

  task automatic test_reset();
    logic [7:0] o;
    o = obs();
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL reset_state observed=%b expected=%b", o, 8'h00);
    end
  endtask

  // One scan. restart_at / abort_at: cycle index (after the accepting edge) at which
  // a stray start / an abort is driven for the following edge; -1 disables.
  task automatic run_scan(input logic [3:0] data, input int restart_at, input int abort_at,
                          input string tag);
    logic [7:0] o, e;
    chan = data;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      if (k > 0) @(negedge clk);
      o = obs();
      if (abort_at >= 0 && k == abort_at + 1) begin
        bus.abort = 1'b0;
        e = {4'b0000, exp_result};
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL %s abort_idle k=%0d observed=%b expected=%b", tag, k, o, e);
        end
        return;
      end
      if (k < LAT) begin
        e = {1'b1, 1'b0, 2'(k / PER_CH), exp_result};
      end else begin
        exp_result = data;
        e = {1'b1, 1'b1, 2'b00, data};
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, o, e);
      end
      bus.start = (k == restart_at);
      bus.abort = (k == abort_at);
    end
    bus.start = 1'b0;
    @(negedge clk);
    o = obs();
`ifdef CONTINUOUS_SCAN_EN
    e = {1'b1, 1'b0, 2'b00, exp_result};
`else
    e = {1'b0, 1'b0, 2'b00, exp_result};
`endif
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s after_done observed=%b expected=%b", tag, o, e);
    end
`ifdef CONTINUOUS_SCAN_EN
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
`endif
  endtask

  // Counts done pulses over a quiet window where no scan should be running.
  task automatic expect_quiet(input int cycles, input string tag);
    int n_done = 0;
    int n_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      if (bus.busy !== 1'b0) n_busy++;
    end
    checks++;
    if (n_done != 0 || n_busy != 0 || bus.result !== exp_result) begin
      errors++;
      $display("FAIL %s quiet done_cycles=%0d busy_cycles=%0d result=%b expected_result=%b",
               tag, n_done, n_busy, bus.result, exp_result);
    end
  endtask

  task automatic test_basic();
    run_scan(4'b0101, -1, -1, "basic_0101");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_scan(4'($urandom_range(0, 15)), -1, -1, "random");
  endtask

  task automatic test_busy_start();
    run_scan(4'b0101, 5, -1, "busy_start");
    expect_quiet(2 * LAT, "busy_start");
  endtask

  task automatic test_abort();
    run_scan(4'b1010, -1, 7, "abort");
    expect_quiet(2 * LAT, "abort");
    run_scan(4'b1111, -1, -1, "after_abort_1111");
  endtask

  task automatic test_abort_late();
    run_scan(4'($urandom_range(0, 15)), -1, LAT - 1, "abort_in_sample");
    expect_quiet(LAT, "abort_in_sample");
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || {bus.s1, bus.s0} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort_idle busy=%b sel=%b expected busy=0 sel=00",
               bus.busy, {bus.s1, bus.s0});
    end
    expect_quiet(LAT, "start_abort_idle");
  endtask

  task automatic test_reset_mid_scan();
    chan = 4'b1011;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_result = 4'b0000;
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_scan observed=%b expected=%b", obs(), 8'h00);
    end
    rst_n = 1'b1;
    expect_quiet(2 * LAT, "reset_mid_scan");
  endtask

`ifdef CONTINUOUS_SCAN_EN
  task automatic test_continuous();
    int c;
    chan = 4'($urandom_range(0, 15));
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      c = 0;
      while (bus.done !== 1'b1 && c < 3 * LAT) begin
        @(negedge clk);
        c++;
      end
      checks++;
      if (c != ((n == 0) ? LAT : LAT + 1) || bus.result !== chan) begin
        errors++;
        $display("FAIL continuous scan=%0d gap=%0d expected_gap=%0d result=%b expected=%b",
                 n, c, (n == 0) ? LAT : LAT + 1, bus.result, chan);
      end
      exp_result = chan;
      chan[3] = ~chan[3];
      @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    expect_quiet(2 * LAT, "continuous_abort");
  endtask
`endif

  initial begin
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    chan       = 4'b0000;
    exp_result = 4'b0000;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_busy_start();
    test_abort();
    test_random();
    test_abort_late();
    test_start_abort_idle();
    test_reset_mid_scan();
`ifdef CONTINUOUS_SCAN_EN
    test_continuous();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
